seq_shift_add_mult: RTL
=======================

# seq_shift_add_mult

Parametrised sequential shift-and-add multiplier with a valid/ready handshake on both sides. It consumes STEP multiplier bits per cycle and supports unsigned and, optionally, two's-complement operands. The output is held until the consumer accepts it. It is the datapath-facing multiplier for wide-operand arithmetic units, trading latency (WIDTH/STEP cycles) for a single (WIDTH+STEP+1)-bit adder.

## Interface
- WIDTH, 128, operand width; must be ≥4 and a multiple of STEP
- STEP, 1, multiplier bits retired per cycle; legal values 1, 2, 4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- in0  input  WIDTH  multiplier
- in1  input  WIDTH  multiplicand
- sgn  input  1  1 = operands are two's complement; sampled with the operands
- out_valid  output  1  product available
- out_ready  input  1  consumer accepts product
- out  output  2*WIDTH  product; stable while out_valid=1
- busy  output  1  state RUN

## Operation
- States:
  - IDLE → RUN on accept (in_valid && in_ready).
  - RUN → DONE after N = WIDTH/STEP digit cycles.
  - DONE → IDLE on out_ready, or DONE → RUN if a new accept happens in the same cycle.
- in_ready is 1 in IDLE. In DONE, in_ready = out_ready (combinational path, allows back-to-back operations). In RUN, in_ready = 0.
- Accept edge:
  - Latch in0 into the multiplier shift register, in1 into the multiplicand register, and sgn.
  - Clear the accumulator, clear cnt, and drop out_valid.
- Each RUN edge:
  - d = low STEP bits of the multiplier register. Partial product pp = d × multiplicand.
  - sum = accumulator upper half + pp, computed at WIDTH+STEP+1 bits.
  - The accumulator shifts right by STEP, with sum written into the top bits.
  - The multiplier register shifts right by STEP, and cnt increments.
- Signed mode:
  - The multiplicand and the accumulator upper half are sign-extended into the adder.
  - The final digit (cnt = N−1) is treated as a signed STEP-bit value, so its partial product is subtracted when the digit MSB is 1.
  - All other digits are unsigned.
- The result is the exact 2*WIDTH-bit product in both modes, with no truncation or overflow.
- in0/in1/sgn changes after the accept edge have no effect.
- in_valid is ignored while in_ready=0. Upstream must hold in_valid and the operands stable until accepted.

## Timing
- Latency: out_valid rises at edge t0+N, where t0 is the accept edge (N=128 at the defaults).
- Throughput: one product per N+1 cycles with out_ready held high. A back-to-back accept in DONE removes the IDLE cycle.
- out_valid stays 1 and out stays unchanged until an edge with out_ready=1.
- out resets to 0 and holds the last product in IDLE. It is not cleared by the next accept until the first RUN edge overwrites it.
- Reset values: out_valid=0, busy=0, out=0, state IDLE, cnt=0. in_ready=1 in the first cycle after rst_n deasserts.
- rst_n asserted mid-RUN or in DONE aborts immediately: the product is discarded and no out_valid pulse occurs.
- cnt is sized $clog2(N+1) bits. Counting never wraps, because RUN exits at cnt=N.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - The sgn input is honoured as described in Operation.
  - The adder carries the sign-extension and subtract path.
- SEQ_MULT_SIGNED_EN undefined:
  - The sgn port remains on the interface but is ignored.
  - All operations are unsigned, and the sign-extension and subtract logic is not synthesised.

## Test plan
- WIDTH=8, STEP=1, unsigned, 0xFF×0xFF → out=0xFE01; out_valid rises exactly 8 cycles after the accept edge; busy=1 during those cycles.
- WIDTH=8, STEP=2, SEQ_MULT_SIGNED_EN, sgn=1: 0x80×0x80 → 0x4000; 0xFF×0x01 → 0xFFFF; 0x7F×0x80 → 0xC080. Latency 4 cycles for each.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out constant, in_ready=0. Then pulse out_ready together with in_valid carrying 0x03×0x05 → accepted the same cycle, next out=0x000F.
- Reset mid-operation: assert rst_n=0 at cnt=3 of 0xAA×0x55 → out=0, out_valid=0, in_ready=1 after release; the next operation 0x02×0x03 → 0x0006.
- Macro undefined, sgn=1, 0xFF×0xFF → 0xFE01 (unsigned result).
- Random regression: 10k operands each for WIDTH=128 with STEP∈{1,2,4} and both sgn values, checked against the reference model product.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - sequential shift-and-add multiplier, STEP bits per cycle
// Optional two's-complement support via SEQ_MULT_SIGNED_EN.
module seq_shift_add_mult #(
  parameter int WIDTH = 128,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int AW = WIDTH + STEP + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             last_digit;
  logic [STEP-1:0]  digit;
  logic [WIDTH-1:0] hi;
  logic [AW-1:0]    hi_ext, mcand_ext, pp, sub, sum;
  logic             ext_m, ext_h, neg_last;

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_RUN);
  assign out        = acc_q;
  assign digit      = mplier_q[STEP-1:0];
  assign last_digit = (cnt_q == CNT_LAST);

  // The accumulator is cleared logically on the first digit so the previous
  // product stays visible on out until the first RUN edge.
  assign hi = (cnt_q == '0) ? '0 : acc_q[2*WIDTH-1:WIDTH];

`ifdef SEQ_MULT_SIGNED_EN
  logic sgn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
    end else if (accept) begin
      sgn_q <= sgn;
    end
  end

  assign ext_m    = sgn_q & mcand_q[WIDTH-1];
  assign ext_h    = sgn_q & hi[WIDTH-1];
  assign neg_last = sgn_q & last_digit & digit[STEP-1];
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign ext_m      = 1'b0;
  assign ext_h      = 1'b0;
  assign neg_last   = 1'b0;
`endif

  assign hi_ext    = {{(STEP + 1){ext_h}}, hi};
  assign mcand_ext = {{(STEP + 1){ext_m}}, mcand_q};

  // Signed final digit has weight -2^(STEP-1) on its MSB: add d*M, then take 2^STEP*M back off.
  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++) begin
      if (digit[i]) begin
        pp = pp + (mcand_ext << i);
      end
    end
    sub = neg_last ? (mcand_ext << STEP) : '0;
    sum = hi_ext + pp - sub;
  end

  logic unused_sum_msb;
  assign unused_sum_msb = sum[AW-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    case (state_q)
      S_RUN: begin
        acc_d    = {sum[WIDTH+STEP-1:0], acc_q[WIDTH-1:STEP]};
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d  = S_RUN;
      cnt_d    = '0;
      mplier_d = in0;
      mcand_d  = in1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
    end
  end

endmodule
